muldiv_unit: RTL

//   Iterative multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//   - Owns the HI/LO registers. The datapath reads them combinationally for MFHI/MFLO.
//   - Runs beside the single-cycle ALU. Computes one radix-2 step per clock.
//   - The controller stalls on busy.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS datapath slice.
//   md_op_e    - multiply/divide unit op codes (MULT, MULTU, DIV, DIVU)
//   md_state_e - multiply/divide unit FSM states
//   md_is_div / md_is_signed - op-code decode helpers
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration of the mul/div unit.
// Ports:
//   div_i   - 1: restoring-divide step, 0: shift-add multiply step
//   acc_i   - 2*WIDTH accumulator
//             multiply: {partial product high, multiplier remaining}
//             divide:   {partial remainder, dividend bits / quotient bits}
//   opnd_i  - multiplicand (multiply) or divisor magnitude (divide)
//   acc_o   - accumulator after this step
//   qbit_o  - quotient bit produced by this step (divide only)
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    logic [WIDTH:0] sum;      // multiply: high half plus multiplicand, with carry
    logic [WIDTH:0] shifted;  // divide: partial remainder shifted left, next dividend bit in
    logic [WIDTH:0] diff;     // divide: trial subtraction; MSB is the borrow

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        // shifted < 2*divisor, so a non-negative difference always fits in WIDTH bits
        // and a negative one always sets the top bit.
        diff    = shifted - {1'b0, opnd_i};
        qbit_o  = ~diff[WIDTH];
        if (div_i) begin
            acc_o = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                     acc_i[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning HI/LO (MULT, MULTU, DIV, DIVU,
// MTHI, MTLO). One radix-2 step per clock; busy for WIDTH+1 cycles per operation.
// Ports:
//   clk, reset      - clock; asynchronous active-high reset
//   start, op, a, b - operation request (sampled only while idle)
//   hi_we, lo_we,wd - MTHI/MTLO writes (only while idle and not starting)
//   busy            - operation in progress
//   done            - one-cycle pulse when HI/LO hold a new result
//   div_by_zero     - with done: divisor was zero; held until next done/reset
//   hi, lo          - HI/LO registers, read combinationally by the datapath
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;        // negate product / quotient
    logic               neg_rem_q, neg_rem_d;  // negate remainder
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;    // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    md_op_e             op_e;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_qbit;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        raw_a_d   = raw_a_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        op_e      = md_op_e'(op);
        sgn       = md_is_signed(op_e);
        // Two's-complement negation of the most-negative value wraps to itself,
        // which is its correct unsigned magnitude.
        mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b     = (sgn && b[WIDTH-1]) ? -b : b;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    div_d     = md_is_div(op_e);
                    opnd_d    = md_is_div(op_e) ? mag_b : mag_a;
                    acc_d     = {{WIDTH{1'b0}}, (md_is_div(op_e) ? mag_a : mag_b)};
                    raw_a_d   = a;
                    bzero_d   = (b == '0);
                    neg_d     = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn & a[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = MD_CALC;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            MD_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = MD_FIX;
            end
            MD_FIX: begin
                if (div_q) begin
                    if (bzero_q) begin
                        lo_d = '1;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                        hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                dbz_d   = div_q & bzero_q;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            raw_a_q   <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            raw_a_q   <= raw_a_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // The quotient bit is already folded into the accumulator's LSB.
    logic unused_qbit;
    assign unused_qbit = step_qbit;

    assign busy        = (state_q != MD_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
